// File: rtl/myniosiicpu_key_irq_pio.sv
// Avalon-MM input PIO: synchronised key/switch inputs with per-bit edge
// capture (write-1-to-clear) and a maskable level interrupt.
module myniosiicpu_key_irq_pio #(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [2:0]       r_settle;

    logic [WIDTH-1:0] w_sync_q;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdata;
    logic             w_wr;
    logic             w_armed;
    logic             w_unused;

    assign w_sync_q = r_sync[SYNC_STAGES-1];
    assign w_wr     = chipselect & ~write_n;
    assign w_armed  = (r_settle == SETTLE);
    assign w_unused = &{1'b0, writedata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync_q;
        end
    end

    // Hold off edge detection until the chain and prev hold real input values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle <= '0;
        end else if (!w_armed) begin
            r_settle <= r_settle + 3'd1;
        end
    end

    assign w_rise = w_sync_q & ~r_prev;
    assign w_fall = ~w_sync_q & r_prev;

    always_comb begin
        w_edge = '0;
        if (w_armed) begin
            if (EDGE_TYPE == 0) begin
                w_edge = w_rise;
            end else if (EDGE_TYPE == 1) begin
                w_edge = w_fall;
            end else begin
                w_edge = w_rise | w_fall;
            end
        end
    end

    assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irqmask <= '0;
            r_edgecap <= '0;
        end else begin
            if (w_wr && address == 2'd2) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            // A fresh edge overrides a same-cycle clear
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    always_comb begin
        w_rdata = '0;
        unique case (address)
            2'd0: w_rdata[WIDTH-1:0] = w_sync_q;
            2'd2: w_rdata[WIDTH-1:0] = r_irqmask;
            2'd3: w_rdata[WIDTH-1:0] = r_edgecap;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= w_rdata;
        end
    end

    assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_myniosiicpu_key_irq_pio.sv
// Directed test of the key IRQ PIO (WIDTH=4, falling edge, 2-stage sync).
module tb_myniosiicpu_key_irq_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    myniosiicpu_key_irq_pio #(
        .WIDTH(4),
        .EDGE_TYPE(1),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    logic [31:0] v;

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        tick(3);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // 1: inputs high through reset produce no capture
        reset   = 1'b0;
        address = 2'd3;
        tick(10);
        check("t1_edgecap", readdata, 32'h0);
        check("t1_irq", {31'b0, irq}, 32'h0);
        rd(2'd0, v);
        check("t1_data", v, 32'h0000000F);

        // 2: falling edge on bit 0, two-edge latency
        wr(2'd2, 32'h1);
        rd(2'd2, v);
        check("t2_mask", v, 32'h1);
        address = 2'd0;
        in_port = 4'hE;
        tick();
        check("t2_irq_k", {31'b0, irq}, 32'h0);
        tick();
        check("t2_irq_k1", {31'b0, irq}, 32'h0);
        check("t2_data_k1", readdata, 32'hF);
        tick();
        check("t2_irq_k2", {31'b0, irq}, 32'h1);
        check("t2_data_k2", readdata, 32'hE);
        rd(2'd3, v);
        check("t2_edgecap", v, 32'h1);

        // 3: W1C clears, writing 0 leaves captures alone
        wr(2'd3, 32'h1);
        check("t3_irq_clr", {31'b0, irq}, 32'h0);
        rd(2'd3, v);
        check("t3_edgecap0", v, 32'h0);
        in_port = 4'hA;
        tick(3);
        wr(2'd3, 32'h0);
        rd(2'd3, v);
        check("t3_bit2_kept", v, 32'h4);
        check("t3_irq_masked", {31'b0, irq}, 32'h0);

        // 4: clear and new edge on bit 0 in the same cycle
        in_port = 4'hB;
        tick(3);
        in_port = 4'hA;
        tick(2);
        wr(2'd3, 32'h1);
        check("t4_irq", {31'b0, irq}, 32'h1);
        rd(2'd3, v);
        check("t4_edgecap", v, 32'h5);

        // 5: mask gating
        wr(2'd2, 32'h0);
        check("t5_irq_mask0", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h4);
        check("t5_irq_mask4", {31'b0, irq}, 32'h1);

        // 6: asynchronous reset mid-operation
        address = 2'd3;
        tick();
        check("t6_pre_rd", readdata, 32'h5);
        #2;
        reset = 1'b1;
        #1;
        check("t6_irq_async", {31'b0, irq}, 32'h0);
        check("t6_rd_async", readdata, 32'h0);
        tick(2);
        reset = 1'b0;
        rd(2'd2, v);
        check("t6_mask", v, 32'h0);
        rd(2'd3, v);
        check("t6_edgecap", v, 32'h0);
        wr(2'd0, 32'hF);
        wr(2'd1, 32'hF);
        tick(8);
        rd(2'd1, v);
        check("t6_rsvd", v, 32'h0);
        rd(2'd0, v);
        check("t6_data", v, 32'hA);
        rd(2'd3, v);
        check("t6_no_spurious", v, 32'h0);
        check("t6_irq", {31'b0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
